// File: rtl/ireg_border_skew.sv
// ireg_border_skew: west-edge input border buffer for the systolic array.
// Channel k is delayed 1+k*LAT beats so the PE rows see a diagonal wavefront.
module ireg_border_skew #(
  parameter int WIDTH = 8,
  parameter int CHAN  = 4,
  parameter int LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  i_valid,
  input  logic                  i_last,
  input  logic [CHAN*WIDTH-1:0] i_data,
  output logic [CHAN*WIDTH-1:0] o_data,
  output logic [CHAN-1:0]       o_valid,
  output logic                  o_last,
  output logic                  o_busy
);

  localparam int DL = 1 + (CHAN-1)*LAT;

  logic [CHAN-1:0] ch_busy;
  logic [DL-1:0]   lst;

  for (genvar k = 0; k < CHAN; k++) begin : g_ch
    localparam int D = 1 + k*LAT;

    logic [WIDTH-1:0] dat [D];
    logic [D-1:0]     vld;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < D; j++) dat[j] <= '0;
        vld <= '0;
      end else if (clr) begin
        for (int j = 0; j < D; j++) dat[j] <= '0;
        vld <= '0;
      end else if (en) begin
        // invalid beats enter as zero so idle PEs multiply by 0
        dat[0] <= i_valid ? i_data[k*WIDTH +: WIDTH] : '0;
        vld[0] <= i_valid;
        for (int j = 1; j < D; j++) begin
          dat[j] <= dat[j-1];
          vld[j] <= vld[j-1];
        end
      end
    end

    assign o_data[k*WIDTH +: WIDTH] = dat[D-1];
    assign o_valid[k]               = vld[D-1];
    assign ch_busy[k]               = |vld;
  end

  // last marker rides only the longest chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lst <= '0;
    end else if (clr) begin
      lst <= '0;
    end else if (en) begin
      lst[0] <= i_valid & i_last;
      for (int j = 1; j < DL; j++) lst[j] <= lst[j-1];
    end
  end

  assign o_last = lst[DL-1];
  assign o_busy = |ch_busy;

endmodule

// File: tb/tb_ireg_border_skew.sv
// tb_ireg_border_skew: hand-derived vector table on a 4x8 instance and
// a queue scoreboard against a random stream on an 8x16, LAT=2 instance.
module tb_ireg_border_skew;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // small instance: WIDTH=8 CHAN=4 LAT=1
  logic        a_en, a_clr, a_v, a_l;
  logic [31:0] a_d, a_od;
  logic [3:0]  a_ov;
  logic        a_ol, a_ob;

  ireg_border_skew #(.WIDTH(8), .CHAN(4), .LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .clr(a_clr),
    .i_valid(a_v), .i_last(a_l), .i_data(a_d),
    .o_data(a_od), .o_valid(a_ov), .o_last(a_ol), .o_busy(a_ob)
  );

  // large instance: WIDTH=16 CHAN=8 LAT=2
  logic         b_en, b_clr, b_v, b_l;
  logic [127:0] b_d, b_od;
  logic [7:0]   b_ov;
  logic         b_ol, b_ob;

  ireg_border_skew #(.WIDTH(16), .CHAN(8), .LAT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .clr(b_clr),
    .i_valid(b_v), .i_last(b_l), .i_data(b_d),
    .o_data(b_od), .o_valid(b_ov), .o_last(b_ol), .o_busy(b_ob)
  );

  // scoreboard for the large instance
  typedef struct packed {
    logic [15:0] d;
    logic        v;
    logic        l;
  } beat_t;

  beat_t q [8][$];
  beat_t tail [8];

  task automatic m_clear();
    for (int k = 0; k < 8; k++) begin
      q[k].delete();
      repeat (2*k) q[k].push_back('0);
      tail[k] = '0;
    end
  endtask

  task automatic m_edge();
    beat_t b;
    if (b_clr) begin
      m_clear();
    end else if (b_en) begin
      for (int k = 0; k < 8; k++) begin
        b.v = b_v;
        b.d = b_v ? b_d[k*16 +: 16] : 16'h0;
        b.l = (k == 7) && b_v && b_l;
        q[k].push_back(b);
        tail[k] = q[k].pop_front();
      end
    end
  endtask

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_b(string nm);
    logic [127:0] xd;
    logic [7:0]   xv;
    logic         xb;
    xd = '0;
    xv = '0;
    xb = 1'b0;
    for (int k = 0; k < 8; k++) begin
      xd[k*16 +: 16] = tail[k].d;
      xv[k] = tail[k].v;
      xb |= tail[k].v;
      foreach (q[k][j]) xb |= q[k][j].v;
    end
    chk({nm, "_data"}, b_od, xd);
    chk({nm, "_valid"}, {120'h0, b_ov}, {120'h0, xv});
    chk({nm, "_last"}, {127'h0, b_ol}, {127'h0, tail[7].l});
    chk({nm, "_busy"}, {127'h0, b_ob}, {127'h0, xb});
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  typedef struct {
    bit          en, clr, v, l;
    logic [31:0] d;
    logic [31:0] xd;
    logic [3:0]  xv;
    bit          xl, xb;
  } vec_t;

  vec_t tbl[$];

  task automatic add(bit en, bit clr, bit v, bit l, logic [31:0] d,
                     logic [31:0] xd, logic [3:0] xv, bit xl, bit xb);
    vec_t r;
    r.en = en; r.clr = clr; r.v = v; r.l = l; r.d = d;
    r.xd = xd; r.xv = xv; r.xl = xl; r.xb = xb;
    tbl.push_back(r);
  endtask

  initial begin
    a_en = 1'b0; a_clr = 1'b0; a_v = 1'b0; a_l = 1'b0; a_d = '0;
    b_en = 1'b0; b_clr = 1'b0; b_v = 1'b0; b_l = 1'b0; b_d = '0;
    m_clear();

    // skew: one beat then idle
    add(1,0,1,0,32'h04030201, 32'h00000001, 4'b0001, 0, 1);
    add(1,0,0,0,32'h0,        32'h00000200, 4'b0010, 0, 1);
    add(1,0,0,0,32'h0,        32'h00030000, 4'b0100, 0, 1);
    add(1,0,0,0,32'h0,        32'h04000000, 4'b1000, 0, 1);
    add(1,0,0,0,32'h0,        32'h00000000, 4'b0000, 0, 0);
    // clear beats en and drops the 7F beat
    add(1,0,1,0,32'h11223344, 32'h00000044, 4'b0001, 0, 1);
    add(1,0,1,0,32'h55667788, 32'h00003388, 4'b0011, 0, 1);
    add(1,1,1,0,32'h7F7F7F7F, 32'h00000000, 4'b0000, 0, 0);
    add(1,0,0,0,32'h0,        32'h00000000, 4'b0000, 0, 0);
    add(1,0,0,0,32'h0,        32'h00000000, 4'b0000, 0, 0);
    add(1,0,0,0,32'h0,        32'h00000000, 4'b0000, 0, 0);
    add(1,0,0,0,32'h0,        32'h00000000, 4'b0000, 0, 0);
    // last without valid is ignored
    add(1,0,0,1,32'h5A5A5A5A, 32'h00000000, 4'b0000, 0, 0);
    add(1,0,0,0,32'h0,        32'h00000000, 4'b0000, 0, 0);
    add(1,0,0,0,32'h0,        32'h00000000, 4'b0000, 0, 0);
    add(1,0,0,0,32'h0,        32'h00000000, 4'b0000, 0, 0);
    // tile of -3..1, last on the fifth beat
    add(1,0,1,0,32'hFDFDFDFD, 32'h000000FD, 4'b0001, 0, 1);
    add(1,0,1,0,32'hFEFEFEFE, 32'h0000FDFE, 4'b0011, 0, 1);
    add(1,0,1,0,32'hFFFFFFFF, 32'h00FDFEFF, 4'b0111, 0, 1);
    add(1,0,1,0,32'h00000000, 32'hFDFEFF00, 4'b1111, 0, 1);
    add(1,0,1,1,32'h01010101, 32'hFEFF0001, 4'b1111, 0, 1);
    add(1,0,0,0,32'h0,        32'hFF000100, 4'b1110, 0, 1);
    add(1,0,0,0,32'h0,        32'h00010000, 4'b1100, 0, 1);
    add(1,0,0,0,32'h0,        32'h01000000, 4'b1000, 1, 1);
    add(1,0,0,0,32'h0,        32'h00000000, 4'b0000, 0, 0);
    // stall of three cycles mid-flight
    add(1,0,1,0,32'h04030201, 32'h00000001, 4'b0001, 0, 1);
    add(1,0,0,0,32'h0,        32'h00000200, 4'b0010, 0, 1);
    add(0,0,1,0,32'hAAAAAAAA, 32'h00000200, 4'b0010, 0, 1);
    add(0,0,0,0,32'h0,        32'h00000200, 4'b0010, 0, 1);
    add(0,0,1,1,32'hBBBBBBBB, 32'h00000200, 4'b0010, 0, 1);
    add(1,0,0,0,32'h0,        32'h00030000, 4'b0100, 0, 1);
    add(1,0,0,0,32'h0,        32'h04000000, 4'b1000, 0, 1);
    add(1,0,0,0,32'h0,        32'h00000000, 4'b0000, 0, 0);

    #2;
    chk("rst_a_data", {96'h0, a_od}, 128'h0);
    chk("rst_a_valid", {124'h0, a_ov}, 128'h0);
    chk("rst_a_busy", {126'h0, a_ol, a_ob}, 128'h0);
    chk_b("rst_b");
    #10 rst_n = 1'b1;

    foreach (tbl[i]) begin
      a_en = tbl[i].en; a_clr = tbl[i].clr;
      a_v = tbl[i].v; a_l = tbl[i].l; a_d = tbl[i].d;
      step();
      chk($sformatf("vec%0d_data", i), {96'h0, a_od}, {96'h0, tbl[i].xd});
      chk($sformatf("vec%0d_valid", i), {124'h0, a_ov}, {124'h0, tbl[i].xv});
      chk($sformatf("vec%0d_last", i), {127'h0, a_ol}, {127'h0, tbl[i].xl});
      chk($sformatf("vec%0d_busy", i), {127'h0, a_ob}, {127'h0, tbl[i].xb});
    end

    // random stream against the scoreboard
    for (int c = 0; c < 600; c++) begin
      b_en  = ($urandom_range(0, 3) != 0);
      b_clr = ($urandom_range(0, 59) == 0);
      b_v   = ($urandom_range(0, 2) != 0);
      b_l   = ($urandom_range(0, 4) == 0);
      b_d   = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk_b($sformatf("rnd%0d", c));
    end
    b_clr = 1'b0;
    b_v   = 1'b0;
    b_en  = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step();
      chk_b($sformatf("drain%0d", c));
    end
    chk("drain_busy", {127'h0, b_ob}, 128'h0);

    // reset mid-stream with both instances loaded
    a_en = 1'b1; a_clr = 1'b0; a_v = 1'b1; a_l = 1'b1; a_d = 32'h81828384;
    b_v = 1'b1; b_l = 1'b1; b_d = {8{16'h8001}};
    repeat (3) step();
    chk("pre_rst_busy", {126'h0, a_ob, b_ob}, 128'h3);
    #2 rst_n = 1'b0;
    m_clear();
    #1;
    chk("mid_rst_a_data", {96'h0, a_od}, 128'h0);
    chk("mid_rst_a_valid", {124'h0, a_ov}, 128'h0);
    chk("mid_rst_a_busy", {126'h0, a_ol, a_ob}, 128'h0);
    chk_b("mid_rst_b");
    @(negedge clk);
    rst_n = 1'b1;
    a_en = 1'b0; a_v = 1'b0; b_en = 1'b0; b_v = 1'b0;
    step();
    chk("post_rst_a", {95'h0, a_od, a_ol}, 128'h0);
    chk_b("post_rst_b");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
